// File: rtl/operand_scoreboard.sv
// operand_scoreboard: resolve decode operands against forwarding buses and a per-register pending-write scoreboard
// Ports: rp_addr/rp_used/rf_rdata describe NRP read ports. fw_* describe NFW forwarding sources, where k=0 is the youngest.
// issue_* and retire_* move the pending counters. flush clears them.
// op_value/stall/sb_full are combinational. sb_err is sticky.
module operand_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NRP  = 2,
  parameter int NFW  = 3,
  parameter int CNTW = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NRP*AW-1:0] rp_addr,
  input  logic [NRP-1:0]    rp_used,
  input  logic [NRP*DW-1:0] rf_rdata,
  input  logic [NFW-1:0]    fw_vwe,
  input  logic [NFW*AW-1:0] fw_dest,
  input  logic [NFW*DW-1:0] fw_data,
  input  logic [NFW-1:0]    fw_ok,
  input  logic              issue_fire,
  input  logic              issue_we,
  input  logic [AW-1:0]     issue_dest,
  input  logic              retire_we,
  input  logic [AW-1:0]     retire_dest,
  input  logic              flush,
  output logic [NRP*DW-1:0] op_value,
  output logic              stall,
  output logic              sb_full,
  output logic              sb_err
);
  logic [CNTW-1:0] cnt [NREG];
  logic [NRP-1:0]  hz;
  logic            inc, dec, under;
  always_comb begin : resolve
    logic hit;
    logic [AW-1:0] a;
    op_value = '0;
    hz = '0;
    for (int p = 0; p < NRP; p++) begin
      hit = 1'b0;
      a = rp_addr[p*AW +: AW];
      op_value[p*DW +: DW] = a == '0 ? '0 : rf_rdata[p*DW +: DW];
      if (a != '0) begin
        for (int k = 0; k < NFW; k++)
          if (!hit && fw_vwe[k] && fw_dest[k*AW +: AW] == a) begin
            hit = 1'b1;
            op_value[p*DW +: DW] = fw_data[k*DW +: DW];
            hz[p] = ~fw_ok[k];
          end
        if (!hit && cnt[a] != '0) hz[p] = 1'b1;
      end
    end
  end
  assign sb_full = issue_we && issue_dest != '0 && cnt[issue_dest] == {CNTW{1'b1}};
  assign stall   = |(hz & rp_used) | sb_full;
  assign inc     = issue_fire && issue_we && issue_dest != '0 && !stall;
  assign dec     = retire_we && retire_dest != '0 && cnt[retire_dest] != '0;
  assign under   = retire_we && retire_dest != '0 && cnt[retire_dest] == '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      sb_err <= sb_err | (under & ~flush);
      for (int i = 0; i < NREG; i++) begin
        logic up, dn;
        up = inc && issue_dest == AW'(i);
        dn = dec && retire_dest == AW'(i);
        cnt[i] <= flush ? '0 : (up && !dn) ? cnt[i] + CNTW'(1) : (dn && !up) ? cnt[i] - CNTW'(1) : cnt[i];
      end
    end
endmodule

// File: tb/tb_operand_scoreboard.sv
// tb_operand_scoreboard: directed and random checks of operand_scoreboard against a counting reference model
module tb_operand_scoreboard;
  localparam int NREG = 32, AW = 5, DW = 32, NRP = 2, NFW = 3, CNTW = 2;
  localparam int MAXC = (1 << CNTW) - 1;
  logic clk = 1'b0, resetn;
  logic [NRP*AW-1:0] rp_addr;
  logic [NRP-1:0]    rp_used;
  logic [NRP*DW-1:0] rf_rdata;
  logic [NFW-1:0]    fw_vwe, fw_ok;
  logic [NFW*AW-1:0] fw_dest;
  logic [NFW*DW-1:0] fw_data;
  logic issue_fire, issue_we, retire_we, flush;
  logic [AW-1:0] issue_dest, retire_dest;
  logic [NRP*DW-1:0] op_value;
  logic stall, sb_full, sb_err;
  int mcnt [NREG];
  bit merr, mstall;
  int nchk = 0, nfail = 0;
  operand_scoreboard #(.NREG(NREG), .AW(AW), .DW(DW), .NRP(NRP), .NFW(NFW), .CNTW(CNTW)) dut (
    .clk(clk), .resetn(resetn), .rp_addr(rp_addr), .rp_used(rp_used), .rf_rdata(rf_rdata),
    .fw_vwe(fw_vwe), .fw_dest(fw_dest), .fw_data(fw_data), .fw_ok(fw_ok),
    .issue_fire(issue_fire), .issue_we(issue_we), .issue_dest(issue_dest),
    .retire_we(retire_we), .retire_dest(retire_dest), .flush(flush),
    .op_value(op_value), .stall(stall), .sb_full(sb_full), .sb_err(sb_err));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    nchk++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  task automatic model_clear();
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    merr = 1'b0;
  endtask
  task automatic check_outputs(input string tag);
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    bit hz, hit, any;
    any = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      a = rp_addr[p*AW +: AW];
      v = rf_rdata[p*DW +: DW];
      hz = 1'b0;
      hit = 1'b0;
      if (a == 0) v = '0;
      else begin
        for (int k = 0; k < NFW; k++)
          if (!hit && fw_vwe[k] && fw_dest[k*AW +: AW] == a) begin
            hit = 1'b1;
            if (fw_ok[k]) v = fw_data[k*DW +: DW];
            else hz = 1'b1;
          end
        if (!hit && mcnt[a] != 0) hz = 1'b1;
      end
      if (!hz) chk($sformatf("%s/op%0d", tag, p), op_value[p*DW +: DW], v);
      if (hz && rp_used[p]) any = 1'b1;
    end
    mstall = any || (issue_we && issue_dest != 0 && mcnt[issue_dest] == MAXC);
    chk({tag, "/stall"}, DW'(stall), DW'(mstall));
    chk({tag, "/sb_full"}, DW'(sb_full), DW'(issue_we && issue_dest != 0 && mcnt[issue_dest] == MAXC));
    chk({tag, "/sb_err"}, DW'(sb_err), DW'(merr));
  endtask
  task automatic step(input string tag);
    #2 check_outputs(tag);
    if (flush) for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    else begin
      if (retire_we && retire_dest != 0) begin
        if (mcnt[retire_dest] == 0) merr = 1'b1;
        else mcnt[retire_dest]--;
      end
      if (issue_fire && issue_we && issue_dest != 0 && !mstall) mcnt[issue_dest]++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rp_addr = '0; rp_used = '0; rf_rdata = '0;
    fw_vwe = '0; fw_ok = '1; fw_dest = '0; fw_data = '0;
    issue_fire = 0; issue_we = 0; issue_dest = '0;
    retire_we = 0; retire_dest = '0; flush = 0;
  endtask
  task automatic probe(input int r, input string tag);
    idle();
    rp_addr[AW-1:0] = AW'(r);
    rp_used = 2'b01;
    rf_rdata[DW-1:0] = 32'h1000_0000 + r;
    step(tag);
  endtask
  task automatic issue(input int r, input string tag);
    idle();
    issue_fire = 1; issue_we = 1; issue_dest = AW'(r);
    step(tag);
  endtask
  task automatic retire(input int r, input string tag);
    idle();
    retire_we = 1; retire_dest = AW'(r);
    step(tag);
  endtask
  initial begin
    idle();
    model_clear();
    resetn = 0;
    #12 check_outputs("reset");
    @(posedge clk);
    #1 resetn = 1;
    idle();
    fw_vwe = 3'b111; fw_ok = 3'b111;
    fw_dest = {AW'(5), AW'(5), AW'(5)};
    fw_data = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    rp_addr[AW-1:0] = 5; rp_used = 2'b01;
    #2 chk("fwd_prio_val", op_value[DW-1:0], 32'hAAAA_AAAA);
    step("fwd_prio");
    idle();
    fw_vwe = 3'b001; fw_ok = 3'b110; fw_dest[AW-1:0] = 7;
    rp_addr[2*AW-1:AW] = 7; rp_used = 2'b10;
    #2 chk("loaduse_stall", DW'(stall), 1);
    step("loaduse_used");
    rp_used = 2'b01;
    step("loaduse_unused");
    issue(9, "hidden_issue");
    probe(9, "hidden_wait");
    retire(9, "hidden_retire");
    probe(9, "hidden_clear");
    chk("hidden_rf", op_value[DW-1:0], 32'h1000_0009);
    for (int i = 0; i < 3; i++) issue(3, "sat_fill");
    issue(3, "sat_full");
    probe(3, "sat_hold");
    retire(3, "sat_ret");
    idle();
    issue_fire = 1; issue_we = 1; issue_dest = 3; retire_we = 1; retire_dest = 3;
    step("sat_both");
    for (int i = 0; i < 3; i++) begin
      probe(3, "sat_count");
      retire(3, "sat_drain");
    end
    probe(3, "sat_empty");
    issue(1, "flush_r1");
    issue(2, "flush_r2");
    idle(); flush = 1; issue_fire = 1; issue_we = 1; issue_dest = 6;
    step("flush");
    probe(1, "flush_p1");
    probe(2, "flush_p2");
    probe(6, "flush_p6");
    issue(9, "areset_issue");
    idle(); rp_addr[AW-1:0] = 9; rp_used = 2'b01;
    #2 check_outputs("areset_before");
    @(negedge clk);
    resetn = 0;
    #1 model_clear();
    check_outputs("areset_now");
    #1 resetn = 1;
    @(posedge clk);
    #1 probe(9, "areset_after");
    retire(4, "err_set");
    idle(); flush = 1;
    step("err_flush");
    probe(4, "err_sticky");
    idle();
    fw_vwe = 3'b111; fw_ok = 3'b000; rp_used = 2'b11;
    rf_rdata = {32'h1234_5678, 32'h9ABC_DEF0};
    step("r0_read");
    issue(0, "r0_issue");
    for (int r = 1; r < NREG; r++) probe(r, "r0_scan");
    for (int n = 0; n < 500; n++) begin
      idle();
      for (int p = 0; p < NRP; p++) rp_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      rp_used = NRP'($urandom);
      rf_rdata = {$urandom, $urandom};
      fw_vwe = NFW'($urandom);
      fw_ok = NFW'($urandom);
      for (int k = 0; k < NFW; k++) fw_dest[k*AW +: AW] = AW'($urandom_range(0, 7));
      fw_data = {$urandom, $urandom, $urandom};
      issue_fire = 1'($urandom);
      issue_we = ($urandom_range(0, 3) != 0);
      issue_dest = AW'($urandom_range(0, 7));
      flush = ($urandom_range(0, 39) == 0);
      retire_we = !flush && ($urandom_range(0, 2) != 0);
      retire_dest = AW'($urandom_range(1, 7));
      step("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
